// File: rtl/video_fetch.sv
// -----------------------------------------------------------------------------
// video_fetch
//
// Per-line mono video fetcher. At the start of each visible line it reads a
// 16-bit word W from a roller table indexed by line number. W is the screen
// line's word address. It then streams LINE_BYTES bytes into a line buffer,
// one byte every 8 byte-addresses, and shifts the buffered line out MSB-first
// as a 1-bit pixel, one pixel per pixel strobe.
//
// If the fetch has not finished by the end of horizontal blanking, the line
// is blanked and a sticky underrun flag is raised.
//
// Ports
//   i_clk          system clock, all state on rising edge
//   i_rst          asynchronous active-high reset
//   i_pix_stb      pixel clock enable from the sync generator
//   i_linestart    one-strobe pulse at h_count 0 (qualified by i_pix_stb)
//   i_hblank       horizontal blanking flag
//   i_vblank       vertical blanking flag
//   i_active       active-video flag
//   i_y            current line number
//   i_roller_addr  byte address of the roller table
//   i_screen_en    display enable
//   i_invert       pixel inversion
//   o_mem_rd       read request, held until acknowledged
//   o_mem_addr     read byte address, stable while o_mem_rd waits for ack
//   i_mem_ack      read acknowledge, i_mem_data valid in the same cycle
//   i_mem_data     read data
//   o_pixel        mono pixel, one pixel strobe after its px position
//   o_underrun     sticky: a line fetch missed its deadline
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module video_fetch #(
  parameter int LINE_BYTES = 90
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_linestart,
  input  logic        i_hblank,
  input  logic        i_vblank,
  input  logic        i_active,
  input  logic [8:0]  i_y,
  input  logic [16:0] i_roller_addr,
  input  logic        i_screen_en,
  input  logic        i_invert,
  output logic        o_mem_rd,
  output logic [16:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_data,
  output logic        o_pixel,
  output logic        o_underrun
);

  localparam int               COL_W    = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_BYTES - 1);
  localparam logic [10:0]      PX_END   = 11'(8 * LINE_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    ROLL_LO,
    ROLL_HI,
    FETCH,
    READY
  } state_t;

  state_t           state;
  logic [8:0]       y_q;
  logic [15:0]      w_q;
  logic [COL_W-1:0] col_q;
  logic             line_valid;
  logic             line_late;    // deadline missed during the current line
  logic             hblank_q;     // i_hblank as seen at the previous strobe
  logic [9:0]       px_q;

  logic [7:0]       linebuf [LINE_BYTES];

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic             ls_strobe;
  logic             ls_go;
  logic             fetching;
  logic             deadline_miss;
  logic             ack;
  logic             lb_we;
  logic [16:0]      roll_lo_addr;
  logic [COL_W-1:0] col_next;

  assign ls_strobe     = i_pix_stb & i_linestart;
  assign ls_go         = ls_strobe & ~i_vblank & i_screen_en;
  assign fetching      = (state == ROLL_LO) || (state == ROLL_HI) || (state == FETCH);
  assign deadline_miss = i_pix_stb & hblank_q & ~i_hblank & fetching;
  // An ack only means something while a request is outstanding.
  assign ack           = i_mem_ack & o_mem_rd;
  // A linestart aborts the fetch in the same cycle, so an ack arriving on
  // that edge belongs to the abandoned line and must not touch the buffer.
  assign lb_we         = (state == FETCH) & ack & ~ls_strobe;
  assign roll_lo_addr  = i_roller_addr + {7'd0, i_y, 1'b0};
  assign col_next      = col_q + COL_W'(1);

  // ---------------------------------------------------------------------------
  // Fetch FSM with registered memory interface
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of
  // statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      y_q        <= '0;
      w_q        <= '0;
      col_q      <= '0;
      line_valid <= 1'b0;
      line_late  <= 1'b0;
      hblank_q   <= 1'b0;
      o_mem_rd   <= 1'b0;
      o_mem_addr <= '0;
      o_underrun <= 1'b0;
    end else begin
      if (i_pix_stb) begin
        hblank_q <= i_hblank;
      end
      if (deadline_miss) begin
        o_underrun <= 1'b1;
      end

      if (ls_strobe) begin
        // Linestart overrides whatever the FSM was doing.
        line_valid <= 1'b0;
        line_late  <= 1'b0;
        col_q      <= '0;
        if (ls_go) begin
          state      <= ROLL_LO;
          y_q        <= i_y;
          o_mem_rd   <= 1'b1;
          o_mem_addr <= roll_lo_addr;
        end else begin
          state    <= IDLE;
          o_mem_rd <= 1'b0;
        end
      end else begin
        if (deadline_miss) begin
          line_late <= 1'b1;
        end

        case (state)
          ROLL_LO: begin
            if (ack) begin
              w_q[7:0]   <= i_mem_data;
              state      <= ROLL_HI;
              o_mem_addr <= i_roller_addr + {7'd0, y_q, 1'b1};
            end
          end

          ROLL_HI: begin
            if (ack) begin
              w_q[15:8]  <= i_mem_data;
              col_q      <= '0;
              state      <= FETCH;
              // W is a word address; the first screen byte is at 2*W.
              o_mem_addr <= {i_mem_data, w_q[7:0], 1'b0};
            end
          end

          FETCH: begin
            if (ack) begin
              if (col_q == LAST_COL) begin
                state      <= READY;
                o_mem_rd   <= 1'b0;
                // A miss on this very edge also disqualifies the line.
                line_valid <= ~(line_late | deadline_miss);
              end else begin
                col_q      <= col_next;
                o_mem_addr <= {w_q, 1'b0} + 17'({col_next, 3'b000});
              end
            end
          end

          default: begin
            // IDLE and READY wait for the next linestart.
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffer: one write port (fetch), one read port (display)
  // ---------------------------------------------------------------------------
  // NOTE: the buffer has no reset; every entry is rewritten before a line is
  // marked valid, so clearing it would only cost a reset fan-out to storage.
  always_ff @(posedge i_clk) begin
    if (lb_we) begin
      linebuf[col_q] <= i_mem_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel shifter
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] rd_idx;
  logic [7:0]       rd_byte;
  logic             px_in_range;
  logic             pix_next;

  assign rd_idx      = COL_W'(px_q >> 3);
  assign rd_byte     = linebuf[rd_idx];
  assign px_in_range = ({1'b0, px_q} < PX_END);

  // NOTE: always_comb assigns a default first so no path leaves pix_next
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pix_next = 1'b0;
    if (i_active && line_valid && i_screen_en && px_in_range) begin
      // MSB first: bit index 7 - px%8 is the bitwise complement of px[2:0].
      pix_next = rd_byte[~px_q[2:0]] ^ i_invert;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      px_q    <= '0;
      o_pixel <= 1'b0;
    end else if (i_pix_stb) begin
      o_pixel <= pix_next;
      if (ls_strobe) begin
        px_q <= '0;
      end else if (i_active) begin
        px_q <= px_q + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_fetch.sv
// -----------------------------------------------------------------------------
// tb_video_fetch
//
// Directed bench for video_fetch. A small memory responder acknowledges every
// request with zero wait (unless held off) and returns roller words and
// screen bytes derived from the address. The stimulus walks through a normal
// line, inversion and line-end boundary, an underrun, a mid-fetch restart,
// blanked lines and an asynchronous reset during ROLL_HI.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_video_fetch;

  localparam int LB = 90;

  logic        i_clk         = 1'b0;
  logic        i_rst         = 1'b1;
  logic        i_pix_stb     = 1'b0;
  logic        i_linestart   = 1'b0;
  logic        i_hblank      = 1'b1;
  logic        i_vblank      = 1'b0;
  logic        i_active      = 1'b0;
  logic [8:0]  i_y           = '0;
  logic [16:0] i_roller_addr = 17'h01000;
  logic        i_screen_en   = 1'b1;
  logic        i_invert      = 1'b0;
  logic        i_mem_ack     = 1'b0;
  logic [7:0]  i_mem_data    = 8'h00;
  logic        o_mem_rd;
  logic [16:0] o_mem_addr;
  logic        o_pixel;
  logic        o_underrun;

  always #5 i_clk = ~i_clk;

  video_fetch #(.LINE_BYTES(LB)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pix_stb     (i_pix_stb),
    .i_linestart   (i_linestart),
    .i_hblank      (i_hblank),
    .i_vblank      (i_vblank),
    .i_active      (i_active),
    .i_y           (i_y),
    .i_roller_addr (i_roller_addr),
    .i_screen_en   (i_screen_en),
    .i_invert      (i_invert),
    .o_mem_rd      (o_mem_rd),
    .o_mem_addr    (o_mem_addr),
    .i_mem_ack     (i_mem_ack),
    .i_mem_data    (i_mem_data),
    .o_pixel       (o_pixel),
    .o_underrun    (o_underrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Memory model contents
  logic [8:0]  cur_y     = '0;
  logic [7:0]  rl        = 8'h34;
  logic [7:0]  rh        = 8'h12;
  logic [7:0]  fetch_xor = 8'hA5;
  logic        ack_hold  = 1'b0;
  logic        force_ack = 1'b0;
  logic [16:0] ack_log [$];

  function automatic logic [7:0] mem_byte(input logic [16:0] a);
    logic [16:0] lo;
    logic [16:0] scr;
    logic [16:0] off;
    lo  = i_roller_addr + {7'd0, cur_y, 1'b0};
    scr = {rh, rl, 1'b0};
    if (a == lo)         return rl;
    if (a == lo + 17'd1) return rh;
    off = a - scr;
    return off[10:3] ^ fetch_xor;
  endfunction

  function automatic logic [7:0] screen_byte(input int k);
    return 8'(k) ^ fetch_xor;
  endfunction

  // Zero-wait responder: decides ack for the coming rising edge.
  always @(negedge i_clk) begin
    if (o_mem_rd === 1'b1 && !ack_hold) begin
      i_mem_ack  = 1'b1;
      i_mem_data = mem_byte(o_mem_addr);
      ack_log.push_back(o_mem_addr);
    end else begin
      i_mem_ack  = force_ack;
      i_mem_data = 8'hFF;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic pix, input logic ls, input logic hb, input logic act);
    i_pix_stb   = pix;
    i_linestart = ls;
    i_hblank    = hb;
    i_active    = act;
    @(posedge i_clk);
    #1;
    i_pix_stb   = 1'b0;
    i_linestart = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, i_hblank, 1'b0);
  endtask

  task automatic start_line(input logic [8:0] y);
    cur_y = y;
    i_y   = y;
    ack_log.delete();
    step(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (o_mem_rd === 1'b1 && n < 400) begin
      step(1'b0, 1'b0, i_hblank, 1'b0);
      n++;
    end
    check(tag, o_mem_rd, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;

    // ---------------- reset state ----------------
    idle(3);
    check("rst_mem_rd",   o_mem_rd,   1'b0);
    check("rst_mem_addr", o_mem_addr, 17'h0);
    check("rst_pixel",    o_pixel,    1'b0);
    check("rst_underrun", o_underrun, 1'b0);
    i_rst = 1'b0;
    idle(2);

    // ---------------- line A: y=5, roller 0x1000 ----------------
    start_line(9'd5);
    check("A_rd_after_ls", o_mem_rd,   1'b1);
    check("A_roll_lo",     o_mem_addr, 17'h0100A);
    wait_ready("A_ready");
    check("A_n_reads", ack_log.size(), 92);
    check("A_log_lo",  ack_log[0], 17'h0100A);
    check("A_log_hi",  ack_log[1], 17'h0100B);
    for (int k = 0; k < LB; k++)
      check($sformatf("A_scr_addr_%0d", k), ack_log[k+2], 17'h02468 + 17'(8*k));
    check("A_scr_last", ack_log[91], 17'h02730);

    e = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check($sformatf("A_pix_%0d", k), o_pixel, e[7-k]);
    end
    idle(2);
    check("A_pix_hold", o_pixel, 1'b1);
    check("A_no_underrun", o_underrun, 1'b0);

    // ---------------- line B: y=6, inverted, line-end boundary ----------------
    i_invert = 1'b1;
    start_line(9'd6);
    check("B_roll_lo", o_mem_addr, 17'h0100C);
    wait_ready("B_ready");
    check("B_log_hi", ack_log[1], 17'h0100D);
    e = 8'h5A;
    for (int px = 0; px <= 720; px++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      if (px < 8)    check($sformatf("B_pix_%0d", px), o_pixel, e[7-px]);
      if (px == 300) check("B_pix_300", o_pixel, 1'b1);
      if (px == 719) check("B_pix_719", o_pixel, 1'b1);
      if (px == 720) check("B_pix_720_off", o_pixel, 1'b0);
    end
    i_invert = 1'b0;

    // ---------------- line C: underrun ----------------
    ack_hold = 1'b1;
    start_line(9'd5);
    idle(3);
    check("C_rd_wait",     o_mem_rd,   1'b1);
    check("C_addr_stable", o_mem_addr, 17'h0100A);
    check("C_no_underrun_yet", o_underrun, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);        // hblank falls while still in ROLL_LO
    check("C_underrun", o_underrun, 1'b1);
    ack_hold = 1'b0;
    wait_ready("C_ready");
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check($sformatf("C_pix_blank_%0d", k), o_pixel, 1'b0);
    end

    // ---------------- line D: on time after underrun ----------------
    start_line(9'd5);
    wait_ready("D_ready");
    e = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check($sformatf("D_pix_%0d", k), o_pixel, e[7-k]);
    end
    check("D_underrun_sticky", o_underrun, 1'b1);

    // ---------------- line E: linestart during FETCH at col 40 ----------------
    start_line(9'd7);
    check("E_roll_lo", o_mem_addr, 17'h0100E);
    begin
      int n = 0;
      while (o_mem_addr !== 17'h025A8 && n < 100) begin
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n++;
      end
    end
    check("E_at_col40", o_mem_addr, 17'h025A8);
    rl        = 8'h00;
    rh        = 8'h20;
    fetch_xor = 8'h3C;
    cur_y     = 9'd8;
    i_y       = 9'd8;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    ack_log.delete();
    check("E_restart_rd",   o_mem_rd,   1'b1);
    check("E_restart_addr", o_mem_addr, 17'h01010);
    wait_ready("E_ready");
    check("E_log_lo",  ack_log[0], 17'h01010);
    check("E_scr0",    ack_log[2], 17'h04000);
    for (int px = 0; px < 328; px++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      e = screen_byte(px / 8);
      if (px < 8 || px >= 320)
        check($sformatf("E_pix_%0d", px), o_pixel, e[7 - (px % 8)]);
    end

    // ---------------- line F: vblank, then screen disabled ----------------
    i_vblank = 1'b1;
    ack_log.delete();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("F_vb_no_rd", o_mem_rd, 1'b0);
    idle(10);
    check("F_vb_no_reads", ack_log.size(), 0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check($sformatf("F_vb_pix_%0d", k), o_pixel, 1'b0);
    end
    i_vblank    = 1'b0;
    i_screen_en = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("F_off_no_rd", o_mem_rd, 1'b0);
    idle(5);
    check("F_off_no_reads", ack_log.size(), 0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check($sformatf("F_off_pix_%0d", k), o_pixel, 1'b0);
    end
    i_screen_en = 1'b1;

    // ---------------- line G: async reset during ROLL_HI ----------------
    rl        = 8'h34;
    rh        = 8'h12;
    fetch_xor = 8'hA5;
    start_line(9'd5);
    idle(1);
    check("G_roll_hi_addr", o_mem_addr, 17'h0100B);
    check("G_roll_hi_rd",   o_mem_rd,   1'b1);
    #2;
    i_rst = 1'b1;
    #1;
    check("G_rst_rd",       o_mem_rd,   1'b0);
    check("G_rst_addr",     o_mem_addr, 17'h0);
    check("G_rst_pixel",    o_pixel,    1'b0);
    check("G_rst_underrun", o_underrun, 1'b0);
    idle(2);
    i_rst     = 1'b0;
    force_ack = 1'b1;
    idle(2);
    force_ack = 1'b0;
    check("G_late_ack_rd",   o_mem_rd,   1'b0);
    check("G_late_ack_addr", o_mem_addr, 17'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
